multicycle_main_control: RTL and testbench
==========================================

Name: multicycle_main_control

Overview:
Main control FSM for the multicycle MIPS-style processor. Sequences fetch/decode/execute/memory/writeback, driving every datapath enable and mux select, plus the 3-bit ALUOp consumed by ALUControl.
Stalls on a memory ready handshake and counts retired instructions.

Parameters:
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
opcode  in  6  IR[31:26] from the instruction register
mem_ready  in  1  memory access completes this cycle
IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction register load
RegDst  out  1  write register select: 0 = rt, 1 = rd
MemtoReg  out  1  write data select: 0 = ALUOut, 1 = MDR
RegWrite  out  1  register file write
ALUSrcA  out  1  A select: 0 = PC, 1 = regA
ALUSrcB  out  2  B select: 00 = regB, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
ALUOp  out  3  to ALUControl: 000 R-type, 010 add, 011 and, 100 or, 001 sub/branch
PCSource  out  2  PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load qualified by ALU zero (beq)
illegal_op  out  1  one-cycle pulse on an undecoded opcode
state_dbg  out  4  current state encoding
instr_retired  out  CNT_W  count of completed instructions

Behaviour:
- Reset is asynchronous and active-high. On reset: state=FETCH, instr_retired=0, illegal_op=0.
- While reset is high, all write and strobe outputs (MemRead, MemWrite, IRWrite, RegWrite, PCWrite, PCWriteCond) are forced to 0.
- Outputs are Moore, decoded from state. In memory states, the enables are additionally qualified by mem_ready, as stated per state below.
- Any output not listed for a state is 0.
- States and their outputs:
  - FETCH(0): IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=010, PCSource=00. IRWrite=PCWrite=mem_ready. Stay in FETCH while !mem_ready; go to DECODE when mem_ready.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOp=010 (branch target into ALUOut). Next state by opcode:
    - 100011 (lw) / 101011 (sw) -> MEMADR
    - 000000 -> REXEC
    - 001000 (addi), 001100 (andi), 001101 (ori) -> IEXEC
    - 000100 (beq) -> BEQ
    - 000010 (j) -> JUMP
    - anything else -> FETCH with illegal_op=1 for 1 cycle; not counted as retired.
  - MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=010. Go to MEMRD for lw, MEMWR for sw.
  - MEMRD(3): IorD=1, MemRead=1. Wait on mem_ready, then MEMWB.
  - MEMWB(4): RegDst=0, MemtoReg=1, RegWrite=1. Go to FETCH.
  - MEMWR(5): IorD=1, MemWrite=1. Hold until mem_ready, then FETCH. MemWrite stays high through the wait.
  - REXEC(6): ALUSrcA=1, ALUSrcB=00, ALUOp=000. Go to RWB.
  - RWB(7): RegDst=1, MemtoReg=0, RegWrite=1. Go to FETCH.
  - IEXEC(8): ALUSrcA=1, ALUSrcB=10. ALUOp = 010 (addi), 011 (andi), 100 (ori), from the opcode latched at DECODE. Go to IWB.
  - IWB(9): RegDst=0, MemtoReg=0, RegWrite=1. Go to FETCH.
  - BEQ(10): ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSource=01, PCWriteCond=1. Go to FETCH.
  - JUMP(11): PCSource=10, PCWrite=1. Go to FETCH.
- Opcode is latched into an internal register in DECODE. Later states use only the latched copy, so opcode changes after DECODE are ignored.
- instr_retired increments on the transition into FETCH from MEMWB, MEMWR (on mem_ready), RWB, IWB, BEQ, or JUMP. It wraps modulo 2^CNT_W and never saturates.
- Latencies in cycles, with mem_ready=1 every cycle: lw 5, sw 4, R-type 4, I-type ALU 4, beq 3, j 3.
- Reset asserted mid-instruction returns to FETCH immediately. No partial write completes after reset deasserts.
- Unused state encodings (12-15) go to FETCH on the next clock with all enables 0.

Decomposition:
- Shared package mc_ctrl_pkg holds: state enum, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI, OP_ORI), ALUOp constants (ALUOP_R=000, ALUOP_ADD=010, ALUOP_AND=011, ALUOP_OR=100, ALUOP_SUB=001), and ALUSrcB/PCSource select constants. ALUControl imports the same ALUOp constants.
- One sub-module, mc_ctrl_outdec: purely combinational state+opcode -> control vector. The FSM, opcode latch and counter stay in the top module.

Test Plan:
- lw with mem_ready=1 throughout -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4; instr_retired 0->1.
- sw with mem_ready low for 3 cycles in MEMWR -> MemWrite held high for 4 cycles, IorD=1; RegWrite never asserted; retire count increments once.
- addi, andi, ori back-to-back -> ALUOp in IEXEC is 010, 011, 100 respectively; each takes 4 cycles; instr_retired=3.
- beq -> BEQ state shows PCWriteCond=1, ALUOp=001, PCSource=01. j -> PCWrite=1, PCSource=10; both take 3 cycles.
- opcode 111111 -> illegal_op pulses for 1 cycle, return to FETCH, instr_retired unchanged.
- reset asserted during MEMRD with FETCH stalled (mem_ready=0) -> state_dbg=0 asynchronously, all enables 0, counter cleared; after release, FETCH waits for mem_ready.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle main control FSM and its
// output decoder; ALUControl pulls its ALUOp encodings from here as well.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_IEXEC  = 4'd8,
    S_IWB    = 4'd9,
    S_BEQ    = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [2:0] ALUOP_R   = 3'b000;
  localparam logic [2:0] ALUOP_ADD = 3'b010;
  localparam logic [2:0] ALUOP_AND = 3'b011;
  localparam logic [2:0] ALUOP_OR  = 3'b100;
  localparam logic [2:0] ALUOP_SUB = 3'b001;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       pc_write_cond;
  } ctrl_t;

  // Only the three immediate ALU ops reach IEXEC, so addi is the fallback.
  function automatic logic [2:0] imm_aluop(input logic [5:0] op);
    case (op)
      OP_ANDI: return ALUOP_AND;
      OP_ORI:  return ALUOP_OR;
      default: return ALUOP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Moore output decoder: current state plus latched opcode to the full
// datapath control vector. Unused state codes decode to all-zero.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMMSH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      // Write strobe stays up for the whole memory wait.
      S_MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_REXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REGB;
        ctrl.alu_op    = ALUOP_R;
      end
      S_RWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_IEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = imm_aluop(op);
      end
      S_IWB: begin
        ctrl.reg_write = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REGB;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multicycle processor: state sequencing, opcode
// latch, retired-instruction counter and reset gating of all strobes.
module multicycle_main_control
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             illegal_op,
  output logic [3:0]       state_dbg,
  output logic [CNT_W-1:0] instr_retired
);

  state_t     state;
  logic [5:0] op_q;
  logic       retire;
  ctrl_t      dec;

  mc_ctrl_outdec u_outdec (
    .state     (state),
    .op        (op_q),
    .mem_ready (mem_ready),
    .ctrl      (dec)
  );

  always_comb begin
    retire = 1'b0;
    case (state)
      S_MEMWB, S_RWB, S_IWB, S_BEQ, S_JUMP: retire = 1'b1;
      S_MEMWR:                              retire = mem_ready;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_FETCH;
      illegal_op    <= 1'b0;
      instr_retired <= '0;
    end else begin
      illegal_op <= 1'b0;
      if (retire) instr_retired <= instr_retired + CNT_W'(1);
      case (state)
        S_FETCH: if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW:             state <= S_MEMADR;
            OP_RTYPE:                 state <= S_REXEC;
            OP_ADDI, OP_ANDI, OP_ORI: state <= S_IEXEC;
            OP_BEQ:                   state <= S_BEQ;
            OP_J:                     state <= S_JUMP;
            default: begin
              state      <= S_FETCH;
              illegal_op <= 1'b1;
            end
          endcase
        end
        S_MEMADR: state <= (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (mem_ready) state <= S_MEMWB;
        S_MEMWR:  if (mem_ready) state <= S_FETCH;
        S_REXEC:  state <= S_RWB;
        S_IEXEC:  state <= S_IWB;
        default:  state <= S_FETCH;
      endcase
    end
  end

  // Later states see only this copy, so IR changes after DECODE are ignored.
  always_ff @(posedge clk) begin
    if (state == S_DECODE) op_q <= opcode;
  end

  assign IorD        = dec.iord;
  assign MemRead     = dec.mem_read & ~reset;
  assign MemWrite    = dec.mem_write & ~reset;
  assign IRWrite     = dec.ir_write & ~reset;
  assign RegDst      = dec.reg_dst;
  assign MemtoReg    = dec.mem_to_reg;
  assign RegWrite    = dec.reg_write & ~reset;
  assign ALUSrcA     = dec.alu_src_a;
  assign ALUSrcB     = dec.alu_src_b;
  assign ALUOp       = dec.alu_op;
  assign PCSource    = dec.pc_source;
  assign PCWrite     = dec.pc_write & ~reset;
  assign PCWriteCond = dec.pc_write_cond & ~reset;
  assign state_dbg   = state;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Scenario bench for multicycle_main_control: per-cycle expected state and
// control vector pushed at drive time and popped against the DUT outputs.
module tb_multicycle_main_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [2:0]  ALUOp;
  logic [1:0]  PCSource;
  logic        PCWrite, PCWriteCond, illegal_op;
  logic [3:0]  state_dbg;
  logic [31:0] instr_retired;

  multicycle_main_control #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .illegal_op(illegal_op), .state_dbg(state_dbg),
    .instr_retired(instr_retired)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] JMP = 6'b000010, ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101;
  localparam logic [5:0] BAD = 6'b111111;

  // {IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource,PCWrite,PCWriteCond}
  localparam logic [16:0] C_RST     = {8'b0000_0000, 2'b01, 3'b010, 2'b00, 1'b0, 1'b0};
  localparam logic [16:0] C_FETCH0  = {8'b0100_0000, 2'b01, 3'b010, 2'b00, 1'b0, 1'b0};
  localparam logic [16:0] C_FETCH1  = {8'b0101_0000, 2'b01, 3'b010, 2'b00, 1'b1, 1'b0};
  localparam logic [16:0] C_DEC     = {8'b0000_0000, 2'b11, 3'b010, 2'b00, 1'b0, 1'b0};
  localparam logic [16:0] C_MADR    = {8'b0000_0001, 2'b10, 3'b010, 2'b00, 1'b0, 1'b0};
  localparam logic [16:0] C_MRD     = {8'b1100_0000, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0};
  localparam logic [16:0] C_MWB     = {8'b0000_0110, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0};
  localparam logic [16:0] C_MWR     = {8'b1010_0000, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0};
  localparam logic [16:0] C_REX     = {8'b0000_0001, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0};
  localparam logic [16:0] C_RWB     = {8'b0000_1010, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0};
  localparam logic [16:0] C_IEX_ADD = {8'b0000_0001, 2'b10, 3'b010, 2'b00, 1'b0, 1'b0};
  localparam logic [16:0] C_IEX_AND = {8'b0000_0001, 2'b10, 3'b011, 2'b00, 1'b0, 1'b0};
  localparam logic [16:0] C_IEX_OR  = {8'b0000_0001, 2'b10, 3'b100, 2'b00, 1'b0, 1'b0};
  localparam logic [16:0] C_IWB     = {8'b0000_0010, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0};
  localparam logic [16:0] C_BEQ     = {8'b0000_0001, 2'b00, 3'b001, 2'b01, 1'b0, 1'b1};
  localparam logic [16:0] C_JMP     = {8'b0000_0000, 2'b00, 3'b000, 2'b10, 1'b1, 1'b0};

  int          total;
  int          bad;
  logic [31:0] exp_cnt;
  logic [53:0] sb[$];

  function automatic logic [53:0] obs();
    return {state_dbg, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
            ALUSrcA, ALUSrcB, ALUOp, PCSource, PCWrite, PCWriteCond, illegal_op, instr_retired};
  endfunction

  function automatic string show(input logic [53:0] v);
    return $sformatf("st=%0d cv=%05h ill=%b cnt=%0d", v[53:50], v[49:33], v[32], v[31:0]);
  endfunction

  task automatic apply(input logic [5:0] op, input logic mr, input logic [3:0] est,
                       input logic [16:0] ecv, input logic eill);
    opcode    = op;
    mem_ready = mr;
    sb.push_back({est, ecv, eill, exp_cnt});
  endtask

  task automatic test_reset();
    logic [53:0] e;
    apply(RT, 1'b1, 4'd0, C_RST, 1'b0);
    #1; e = sb.pop_front(); total++;
    if (obs() !== e) begin
      bad++; $display("FAIL reset got %s want %s", show(obs()), show(e));
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_lw();
    logic [53:0] e;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: apply(LW, 1'b1, 4'd0, C_FETCH1, 1'b0);
        1: apply(LW, 1'b1, 4'd1, C_DEC, 1'b0);
        2: apply(SW, 1'b1, 4'd2, C_MADR, 1'b0);
        3: apply(SW, 1'b1, 4'd3, C_MRD, 1'b0);
        4: apply(RT, 1'b1, 4'd4, C_MWB, 1'b0);
        default: begin exp_cnt++; apply(RT, 1'b0, 4'd0, C_FETCH0, 1'b0); end
      endcase
      #1; e = sb.pop_front(); total++;
      if (obs() !== e) begin
        bad++; $display("FAIL lw step=%0d got %s want %s", i, show(obs()), show(e));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_stall();
    logic [53:0] e;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: apply(SW, 1'b1, 4'd0, C_FETCH1, 1'b0);
        1: apply(SW, 1'b1, 4'd1, C_DEC, 1'b0);
        2: apply(LW, 1'b1, 4'd2, C_MADR, 1'b0);
        3, 4, 5: apply(LW, 1'b0, 4'd5, C_MWR, 1'b0);
        6: apply(LW, 1'b1, 4'd5, C_MWR, 1'b0);
        default: begin exp_cnt++; apply(RT, 1'b0, 4'd0, C_FETCH0, 1'b0); end
      endcase
      #1; e = sb.pop_front(); total++;
      if (obs() !== e) begin
        bad++; $display("FAIL sw_stall step=%0d got %s want %s", i, show(obs()), show(e));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_itype_back_to_back();
    logic [53:0] e;
    logic [5:0]  op;
    logic [16:0] iex;
    for (int i = 0; i < 13; i++) begin
      case (i / 4)
        0:       begin op = ADDI; iex = C_IEX_ADD; end
        1:       begin op = ANDI; iex = C_IEX_AND; end
        2:       begin op = ORI;  iex = C_IEX_OR;  end
        default: begin op = RT;   iex = C_IEX_ADD; end
      endcase
      if (i % 4 == 0 && i > 0) exp_cnt++;
      case (i % 4)
        0: apply(op, (i < 12), 4'd0, (i < 12) ? C_FETCH1 : C_FETCH0, 1'b0);
        1: apply(op, 1'b1, 4'd1, C_DEC, 1'b0);
        2: apply(RT, 1'b1, 4'd8, iex, 1'b0);
        default: apply(RT, 1'b1, 4'd9, C_IWB, 1'b0);
      endcase
      #1; e = sb.pop_front(); total++;
      if (obs() !== e) begin
        bad++; $display("FAIL itype step=%0d got %s want %s", i, show(obs()), show(e));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_jump();
    logic [53:0] e;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: apply(BEQ, 1'b1, 4'd0, C_FETCH1, 1'b0);
        1: apply(BEQ, 1'b1, 4'd1, C_DEC, 1'b0);
        2: apply(RT, 1'b1, 4'd10, C_BEQ, 1'b0);
        3: begin exp_cnt++; apply(JMP, 1'b1, 4'd0, C_FETCH1, 1'b0); end
        4: apply(JMP, 1'b1, 4'd1, C_DEC, 1'b0);
        5: apply(RT, 1'b1, 4'd11, C_JMP, 1'b0);
        default: begin exp_cnt++; apply(RT, 1'b0, 4'd0, C_FETCH0, 1'b0); end
      endcase
      #1; e = sb.pop_front(); total++;
      if (obs() !== e) begin
        bad++; $display("FAIL branch_jump step=%0d got %s want %s", i, show(obs()), show(e));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype();
    logic [53:0] e;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: apply(RT, 1'b1, 4'd0, C_FETCH1, 1'b0);
        1: apply(RT, 1'b1, 4'd1, C_DEC, 1'b0);
        2: apply(LW, 1'b1, 4'd6, C_REX, 1'b0);
        3: apply(LW, 1'b1, 4'd7, C_RWB, 1'b0);
        default: begin exp_cnt++; apply(RT, 1'b0, 4'd0, C_FETCH0, 1'b0); end
      endcase
      #1; e = sb.pop_front(); total++;
      if (obs() !== e) begin
        bad++; $display("FAIL rtype step=%0d got %s want %s", i, show(obs()), show(e));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    logic [53:0] e;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: apply(BAD, 1'b1, 4'd0, C_FETCH1, 1'b0);
        1: apply(BAD, 1'b1, 4'd1, C_DEC, 1'b0);
        2: apply(BAD, 1'b0, 4'd0, C_FETCH0, 1'b1);
        default: apply(BAD, 1'b0, 4'd0, C_FETCH0, 1'b0);
      endcase
      #1; e = sb.pop_front(); total++;
      if (obs() !== e) begin
        bad++; $display("FAIL illegal step=%0d got %s want %s", i, show(obs()), show(e));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    logic [53:0] e;
    for (int i = 0; i < 9; i++) begin
      case (i)
        0: apply(LW, 1'b1, 4'd0, C_FETCH1, 1'b0);
        1: apply(LW, 1'b1, 4'd1, C_DEC, 1'b0);
        2: apply(LW, 1'b1, 4'd2, C_MADR, 1'b0);
        3: apply(LW, 1'b0, 4'd3, C_MRD, 1'b0);
        4: begin reset = 1'b1; exp_cnt = '0; apply(LW, 1'b0, 4'd0, C_RST, 1'b0); end
        5, 6: begin reset = 1'b0; apply(LW, 1'b0, 4'd0, C_FETCH0, 1'b0); end
        7: apply(LW, 1'b1, 4'd0, C_FETCH1, 1'b0);
        default: apply(LW, 1'b1, 4'd1, C_DEC, 1'b0);
      endcase
      #1; e = sb.pop_front(); total++;
      if (obs() !== e) begin
        bad++; $display("FAIL reset_mid step=%0d got %s want %s", i, show(obs()), show(e));
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    total     = 0;
    bad       = 0;
    exp_cnt   = '0;
    reset     = 1'b1;
    opcode    = RT;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_lw();
    test_sw_stall();
    test_itype_back_to_back();
    test_branch_jump();
    test_rtype();
    test_illegal();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
